perf_counter_bank: RTL and testbench

Parametrised bank of NUM_CH event counters, CNT_WIDTH bits each, memory-mapped into the top of the lc3b address space.
- Each channel counts single-cycle event strobes from the pipeline and caches (instruction retire, branches, stalls, L1/L2 hit/miss, ...).
- Adds over the existing counter logic: reset, global enable/freeze, software clear and preload, saturate-or-wrap mode, sticky overflow flags, and atomic 32-bit reads through 16-bit accesses.
- Sits beside the memory arbiter. Its hit output steers the CPU read-data mux.

---
 rtl/perf_counter_bank_if.sv | 20 ++
 rtl/perf_counter_bank.sv | 167 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - CPU data-port bundle between the lc3b core and the counter bank
interface perf_counter_bank_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic        counter_hit;
  logic        counter_resp;
  logic [15:0] counter_rdata;

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata,
    input  counter_hit, counter_resp, counter_rdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata,
    output counter_hit, counter_resp, counter_rdata
  );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - memory-mapped event counter bank with shadowed 32-bit reads
// PERF_SNAPSHOT_EN adds a per-channel snapshot bank (CTRL bit3 SNAP, bit4 USE_SNAP).
module perf_counter_bank #(
  parameter int          NUM_CH    = 16,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFFC0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] event_inc_i,
  perf_counter_bank_if.slave bus
);
  localparam logic [15:0]          CTRL_OFF = 16'(2 * NUM_CH);
  localparam logic [15:0]          OVF_OFF  = 16'(2 * NUM_CH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [15:0]          offset;
  logic                 hit, rd_en, wr_en, ctrl_wr, ovf_wr, clr_all, cnt_en;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [31:0]          cnt_w [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d, ovf_set;
  logic                 en_q, en_d, freeze_q, freeze_d;
  logic                 resp_q, resp_d;
  logic [15:0]          shadow_q, shadow_d, rdata_q, rdata_d, ctrl_rd;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
  logic [CNT_WIDTH-1:0] snap_d [NUM_CH];
  logic [31:0]          snap_w [NUM_CH];
  logic                 use_snap_q, use_snap_d;
`endif

  // Offset wraps modulo 2^16, so addresses below the base fall outside the window.
  always_comb begin
    offset  = bus.mem_address - BASE_ADDR;
    hit     = (offset <= OVF_OFF);
    wr_en   = bus.mem_write && hit;
    rd_en   = bus.mem_read && !bus.mem_write && hit;
    ctrl_wr = wr_en && (offset == CTRL_OFF);
    ovf_wr  = wr_en && (offset == OVF_OFF);
    clr_all = ctrl_wr && bus.mem_wdata[2];
    cnt_en  = en_q && !freeze_q;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_w[c] = 32'(cnt_q[c]);
    end
  end

  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clr_all) begin
        cnt_d[c] = '0;
      end else if (wr_en && (offset == 16'(2 * c))) begin
        cnt_d[c] = CNT_WIDTH'({cnt_w[c][31:16], bus.mem_wdata});
      end else if (wr_en && (offset == 16'(2 * c + 1))) begin
        // Truncation drops the high half entirely in 16-bit builds.
        cnt_d[c] = CNT_WIDTH'({bus.mem_wdata, cnt_w[c][15:0]});
      end else if (event_inc_i[c] && cnt_en) begin
        if (cnt_q[c] == CNT_MAX) begin
          ovf_set[c] = 1'b1;
          cnt_d[c]   = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    en_d     = en_q;
    freeze_d = freeze_q;
    if (ctrl_wr) begin
      en_d     = bus.mem_wdata[0];
      freeze_d = bus.mem_wdata[1];
    end
    if (clr_all) begin
      ovf_d = '0;
    end else begin
      ovf_d = ovf_q;
      if (ovf_wr) begin
        ovf_d = ovf_q & ~bus.mem_wdata[NUM_CH-1:0];
      end
      ovf_d = ovf_d | ovf_set;
    end
    ctrl_rd = {14'd0, freeze_q, en_q};
`ifdef PERF_SNAPSHOT_EN
    use_snap_d = use_snap_q;
    if (ctrl_wr) begin
      use_snap_d = bus.mem_wdata[4];
    end
    ctrl_rd[4] = use_snap_q;
`endif
  end

`ifdef PERF_SNAPSHOT_EN
  // Snapshot captures the registered counts, i.e. before this edge's increments.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      snap_w[c] = 32'(snap_q[c]);
      snap_d[c] = (ctrl_wr && bus.mem_wdata[3]) ? cnt_q[c] : snap_q[c];
    end
  end
`endif

  always_comb begin
    resp_d   = rd_en;
    rdata_d  = rdata_q;
    shadow_d = shadow_q;
    if (rd_en) begin
      rdata_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (offset == 16'(2 * c)) begin
          rdata_d  = cnt_w[c][15:0];
          shadow_d = cnt_w[c][31:16];
`ifdef PERF_SNAPSHOT_EN
          if (use_snap_q) rdata_d = snap_w[c][15:0];
`endif
        end else if (offset == 16'(2 * c + 1)) begin
          rdata_d = shadow_q;
`ifdef PERF_SNAPSHOT_EN
          if (use_snap_q) rdata_d = snap_w[c][31:16];
`endif
        end
      end
      if (offset == CTRL_OFF) rdata_d = ctrl_rd;
      if (offset == OVF_OFF)  rdata_d = 16'(ovf_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '{default: '0};
      ovf_q    <= '0;
      en_q     <= 1'b1;
      freeze_q <= 1'b0;
      shadow_q <= '0;
      rdata_q  <= '0;
      resp_q   <= 1'b0;
`ifdef PERF_SNAPSHOT_EN
      snap_q     <= '{default: '0};
      use_snap_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      freeze_q <= freeze_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
`ifdef PERF_SNAPSHOT_EN
      snap_q     <= snap_d;
      use_snap_q <= use_snap_d;
`endif
    end
  end

  assign bus.counter_hit   = hit;
  assign bus.counter_resp  = resp_q;
  assign bus.counter_rdata = rdata_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed and randomized bench for perf_counter_bank
// Three instances share stimulus: 16-bit wrap, 16-bit saturate, 32-bit wrap.
module tb_perf_counter_bank;
  localparam int          NI   = 3;
  localparam int          NC   = 4;
  localparam int          NR   = 1500;
  localparam logic [15:0] BASE = 16'hFFC0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   a   = '0;
  logic [15:0]   wd  = '0;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [NC-1:0] ev  = '0;
  int checks   = 0;
  int failures = 0;

  logic [NI-1:0] hit_o, resp_o;
  logic [15:0]   rdata_o [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    perf_counter_bank_if bus ();
    assign bus.mem_address = a;
    assign bus.mem_read    = rd;
    assign bus.mem_write   = wr;
    assign bus.mem_wdata   = wd;
    assign hit_o[g]   = bus.counter_hit;
    assign resp_o[g]  = bus.counter_resp;
    assign rdata_o[g] = bus.counter_rdata;
    perf_counter_bank #(
      .NUM_CH(NC), .CNT_WIDTH(g == 2 ? 32 : 16), .BASE_ADDR(BASE), .SATURATE(g == 1)
    ) u_dut (
      .clk_i(clk), .reset_i(rst), .event_inc_i(ev), .bus(bus)
    );
  end

  // Reference model: architectural state per instance, updated once per clock edge.
  int unsigned     cw  [NI] = '{16, 16, 32};
  bit              sat [NI] = '{1'b0, 1'b1, 1'b0};
  longint unsigned m_cnt  [NI][NC];
  longint unsigned m_snap [NI][NC];
  int unsigned     m_ovf [NI];
  int unsigned     m_shadow [NI];
  bit              m_en [NI];
  bit              m_frz [NI];
  bit              m_usnap [NI];
  bit              exp_resp [NI];
  logic [15:0]     exp_rdata [NI];

  task automatic model_edge();
    logic [15:0]     off16;
    int unsigned     off, newovf, c;
    longint unsigned mx;
    bit              clr, wr_hit;
    off16 = a - BASE;
    off   = off16;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int k = 0; k < NC; k++) begin
          m_cnt[i][k]  = 0;
          m_snap[i][k] = 0;
        end
        m_ovf[i] = 0; m_shadow[i] = 0; m_en[i] = 1; m_frz[i] = 0; m_usnap[i] = 0;
        exp_resp[i] = 0; exp_rdata[i] = '0;
      end else begin
        mx = (64'd1 << cw[i]) - 1;
        exp_resp[i] = rd && !wr && (off <= 2 * NC + 1);
        if (exp_resp[i]) begin
          if (off < 2 * NC) begin
            c = off / 2;
            if (off % 2 == 0) begin
              exp_rdata[i] = m_usnap[i] ? 16'(m_snap[i][c]) : 16'(m_cnt[i][c]);
              m_shadow[i]  = 32'(m_cnt[i][c] >> 16);
            end else begin
              exp_rdata[i] = m_usnap[i] ? 16'(m_snap[i][c] >> 16) : 16'(m_shadow[i]);
            end
          end else if (off == 2 * NC) begin
            exp_rdata[i] = {11'd0, m_usnap[i], 2'b00, m_frz[i], m_en[i]};
          end else begin
            exp_rdata[i] = 16'(m_ovf[i]);
          end
        end
        wr_hit = wr && (off <= 2 * NC + 1);
        clr    = wr_hit && (off == 2 * NC) && wd[2];
        newovf = 0;
`ifdef PERF_SNAPSHOT_EN
        if (wr_hit && (off == 2 * NC)) begin
          if (wd[3]) for (int k = 0; k < NC; k++) m_snap[i][k] = m_cnt[i][k];
          m_usnap[i] = wd[4];
        end
`endif
        for (int k = 0; k < NC; k++) begin
          if (clr) m_cnt[i][k] = 0;
          else if (wr_hit && off == 2 * k) m_cnt[i][k] = (m_cnt[i][k] & 64'hFFFF_0000) | 64'(wd);
          else if (wr_hit && off == 2 * k + 1) begin
            if (cw[i] == 32) m_cnt[i][k] = (64'(wd) << 16) | (m_cnt[i][k] & 64'hFFFF);
          end else if (ev[k] && m_en[i] && !m_frz[i]) begin
            if (m_cnt[i][k] == mx) begin
              newovf = newovf | (1 << k);
              if (!sat[i]) m_cnt[i][k] = 0;
            end else begin
              m_cnt[i][k] = m_cnt[i][k] + 1;
            end
          end
        end
        if (clr) m_ovf[i] = 0;
        else begin
          if (wr_hit && off == 2 * NC + 1) m_ovf[i] = m_ovf[i] & ~{16'd0, wd};
          m_ovf[i] = m_ovf[i] | newovf;
        end
        if (wr_hit && off == 2 * NC) begin
          m_en[i]  = wd[0];
          m_frz[i] = wd[1];
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic [15:0] ad, input logic r, input logic w,
                       input logic [15:0] d, input logic [NC-1:0] e);
    a = ad; rd = r; wr = w; wd = d; ev = e;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(16'h0000, 0, 0, 16'h0, '0);
    cycle(BASE + 16'd8, 1, 0, 16'h0, '1);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (resp_o[i] !== 1'b0 || rdata_o[i] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d resp=%b rdata=%h exp=0/0000", i, resp_o[i], rdata_o[i]);
      end
    end
    rst = 1'b0;
    cycle(BASE + 16'd8, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (resp_o[i] !== 1'b1 || rdata_o[i] !== 16'h0001) begin
        failures++;
        $display("FAIL reset_ctrl inst=%0d resp=%b rdata=%h exp=1/0001", i, resp_o[i], rdata_o[i]);
      end
    end
    cycle(16'h0000, 0, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (resp_o[i] !== 1'b0 || rdata_o[i] !== 16'h0001) begin
        failures++;
        $display("FAIL resp_single_pulse inst=%0d resp=%b rdata=%h exp=0/0001", i, resp_o[i], rdata_o[i]);
      end
    end
  endtask

  task automatic test_count();
    for (int n = 0; n < 5; n++) cycle(16'h0000, 0, 0, 16'h0, 4'b1000);
    cycle(BASE + 16'd6, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (resp_o[i] !== 1'b1 || rdata_o[i] !== 16'h0005) begin
        failures++;
        $display("FAIL count_ch3 inst=%0d resp=%b rdata=%h exp=1/0005", i, resp_o[i], rdata_o[i]);
      end
    end
  endtask

  task automatic test_wrap_sat();
    logic [15:0] e_cnt [NI] = '{16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] e_ovf [NI] = '{16'h0001, 16'h0001, 16'h0000};
    cycle(BASE + 16'd8, 0, 1, 16'h0005, '0);
    cycle(BASE, 0, 1, 16'hFFFE, '0);
    for (int n = 0; n < 3; n++) cycle(16'h0000, 0, 0, 16'h0, 4'b0001);
    cycle(BASE, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== e_cnt[i]) begin
        failures++;
        $display("FAIL max_count inst=%0d act=%h exp=%h", i, rdata_o[i], e_cnt[i]);
      end
    end
    cycle(BASE + 16'd9, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== e_ovf[i]) begin
        failures++;
        $display("FAIL ovf_sticky inst=%0d act=%h exp=%h", i, rdata_o[i], e_ovf[i]);
      end
    end
    cycle(BASE + 16'd9, 0, 1, 16'h0001, '0);
    cycle(BASE + 16'd9, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== 16'h0000) begin
        failures++;
        $display("FAIL ovf_w1c inst=%0d act=%h exp=0000", i, rdata_o[i]);
      end
    end
  endtask

  task automatic test_cnt32();
    logic [15:0] seq_a [4] = '{BASE + 16'd4, BASE + 16'd5, BASE + 16'd4, BASE + 16'd5};
    logic [15:0] seq_e [4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0002};
    cycle(BASE + 16'd4, 0, 1, 16'hFFFF, '0);
    cycle(BASE + 16'd5, 0, 1, 16'h0001, '0);
    for (int s = 0; s < 4; s++) begin
      cycle(seq_a[s], 1, 0, 16'h0, '0);
      checks++;
      if (rdata_o[2] !== seq_e[s]) begin
        failures++;
        $display("FAIL cnt32_atomic step=%0d act=%h exp=%h", s, rdata_o[2], seq_e[s]);
      end
      if (s == 1) begin
        checks++;
        if (rdata_o[0] !== 16'h0000 || rdata_o[1] !== 16'h0000) begin
          failures++;
          $display("FAIL cnt16_high_zero act=%h/%h exp=0000", rdata_o[0], rdata_o[1]);
        end
      end
      if (s == 0) cycle(16'h0000, 0, 0, 16'h0, 4'b0100);
    end
  endtask

  task automatic test_write_priority();
    cycle(BASE + 16'd2, 0, 1, 16'h1234, 4'b0010);
    cycle(BASE + 16'd3, 0, 1, 16'h00AB, '0);
    cycle(BASE + 16'd2, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== 16'h1234) begin
        failures++;
        $display("FAIL write_beats_inc inst=%0d act=%h exp=1234", i, rdata_o[i]);
      end
    end
    cycle(BASE + 16'd3, 1, 0, 16'h0, '0);
    checks++;
    if (rdata_o[2] !== 16'h00AB) begin
      failures++;
      $display("FAIL write_high_half act=%h exp=00ab", rdata_o[2]);
    end
  endtask

  task automatic test_freeze_clr();
    logic [15:0] e_ovf [NI] = '{16'h0002, 16'h0002, 16'h0000};
    cycle(BASE + 16'd8, 0, 1, 16'h0005, '0);
    for (int c = 0; c < NC; c++) cycle(BASE + 16'(2 * c), 0, 1, 16'h0100 + 16'(c), '0);
    cycle(BASE + 16'd8, 0, 1, 16'h0003, '0);
    for (int n = 0; n < 3; n++) cycle(16'h0000, 0, 0, 16'h0, '1);
    for (int c = 0; c < NC; c++) begin
      cycle(BASE + 16'(2 * c), 1, 0, 16'h0, '0);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (rdata_o[i] !== 16'h0100 + 16'(c)) begin
          failures++;
          $display("FAIL freeze_hold inst=%0d ch=%0d act=%h exp=%h", i, c, rdata_o[i], 16'h0100 + 16'(c));
        end
      end
    end
    cycle(BASE + 16'd8, 0, 1, 16'h0001, '0);
    cycle(BASE + 16'd2, 0, 1, 16'hFFFF, '0);
    cycle(16'h0000, 0, 0, 16'h0, 4'b0010);
    cycle(BASE + 16'd9, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== e_ovf[i]) begin
        failures++;
        $display("FAIL ovf_ch1 inst=%0d act=%h exp=%h", i, rdata_o[i], e_ovf[i]);
      end
    end
    cycle(BASE + 16'd8, 0, 1, 16'h0004, '1);
    cycle(BASE + 16'd8, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== 16'h0000) begin
        failures++;
        $display("FAIL clr_ctrl inst=%0d act=%h exp=0000", i, rdata_o[i]);
      end
    end
    cycle(BASE + 16'd9, 1, 0, 16'h0, '1);
    cycle(16'h0000, 0, 0, 16'h0, '1);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== 16'h0000) begin
        failures++;
        $display("FAIL clr_ovf inst=%0d act=%h exp=0000", i, rdata_o[i]);
      end
    end
    for (int c = 0; c < NC; c++) begin
      cycle(BASE + 16'(2 * c), 1, 0, 16'h0, '0);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (rdata_o[i] !== 16'h0000) begin
          failures++;
          $display("FAIL clr_disabled inst=%0d ch=%0d act=%h exp=0000", i, c, rdata_o[i]);
        end
      end
    end
    cycle(BASE + 16'd8, 0, 1, 16'h0001, '0);
  endtask

  task automatic test_boundary();
    logic [15:0] ba [4] = '{BASE - 16'd1, BASE + 16'(2 * NC + 2), BASE + 16'(2 * NC + 1), BASE};
    bit          bh [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int s = 0; s < 4; s++) begin
      a = ba[s]; rd = 1'b1; wr = 1'b0; wd = '0; ev = '0;
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (hit_o[i] !== bh[s]) begin
          failures++;
          $display("FAIL hit_edge addr=%h inst=%0d act=%b exp=%b", ba[s], i, hit_o[i], bh[s]);
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (resp_o[i] !== bh[s]) begin
          failures++;
          $display("FAIL resp_edge addr=%h inst=%0d act=%b exp=%b", ba[s], i, resp_o[i], bh[s]);
        end
      end
    end
    cycle(BASE, 1, 1, 16'h0055, '0);
    cycle(BASE, 1, 0, 16'h0, '0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdata_o[i] !== 16'h0055) begin
        failures++;
        $display("FAIL rw_both inst=%0d act=%h exp=0055", i, rdata_o[i]);
      end
    end
  endtask

`ifdef PERF_SNAPSHOT_EN
  task automatic test_snapshot();
    logic [15:0] e [3] = '{16'h0011, 16'h000A, 16'h000E};
    logic [15:0] ad [3] = '{BASE + 16'd8, BASE, BASE};
    cycle(BASE + 16'd8, 0, 1, 16'h0005, '0);
    for (int n = 0; n < 10; n++) cycle(16'h0000, 0, 0, 16'h0, 4'b0001);
    cycle(BASE + 16'd8, 0, 1, 16'h0009, 4'b0001);
    for (int n = 0; n < 3; n++) cycle(16'h0000, 0, 0, 16'h0, 4'b0001);
    cycle(BASE + 16'd8, 0, 1, 16'h0011, '0);
    for (int s = 0; s < 3; s++) begin
      if (s == 2) cycle(BASE + 16'd8, 0, 1, 16'h0001, '0);
      cycle(ad[s], 1, 0, 16'h0, '0);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (rdata_o[i] !== e[s]) begin
          failures++;
          $display("FAIL snapshot step=%0d inst=%0d act=%h exp=%h", s, i, rdata_o[i], e[s]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    int  r;
    bit  exp_hit;
    for (int n = 0; n < NR; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      a   = BASE - 16'd2 + 16'($urandom_range(0, 2 * NC + 5));
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 5) == 0);
      wd  = 16'($urandom);
      if (a == BASE + 16'(2 * NC)) begin
        r = $urandom_range(0, 9);
        wd[0] = (r != 0);
        wd[1] = (r == 1);
        wd[2] = (r == 2);
      end else if ($urandom_range(0, 2) == 0) begin
        wd = 16'hFFFF - 16'($urandom_range(0, 3));
      end
      ev = NC'($urandom);
      #1;
      exp_hit = (a >= BASE) && (a <= BASE + 16'(2 * NC + 1));
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (hit_o[i] !== exp_hit) begin
          failures++;
          $display("FAIL rand_hit n=%0d inst=%0d addr=%h act=%b exp=%b", n, i, a, hit_o[i], exp_hit);
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (resp_o[i] !== exp_resp[i] || rdata_o[i] !== exp_rdata[i]) begin
          failures++;
          $display("FAIL rand_read n=%0d inst=%0d resp=%b rdata=%h exp=%b/%h",
                   n, i, resp_o[i], rdata_o[i], exp_resp[i], exp_rdata[i]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap_sat();
    test_cnt32();
    test_write_priority();
    test_freeze_clr();
    test_boundary();
`ifdef PERF_SNAPSHOT_EN
    test_snapshot();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
